// File: rtl/paula_ipl_responder.sv
// paula_ipl_responder: filters the active-low IPL lines, detects NMI edges and
// runs the interrupt-acknowledge handshake towards the CPU bus sequencer.
module paula_ipl_responder (
  input  logic       clk,
  input  logic       _reset,
  input  logic       clk7_en,
  input  logic [2:0] _ipl,
  input  logic [2:0] ipl_mask,
  input  logic       cpu_ready,
  input  logic       iack_ack,
  input  logic       iack_berr,
  output logic       iack_req,
  output logic [2:0] iack_level,
  output logic       int_taken,
  output logic [7:0] vector,
  output logic [2:0] new_mask,
  output logic [2:0] ipl_level
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PEND = 2'd1,
    S_ACK  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [7:0] VEC_BASE = 8'h18;

  state_t     state;
  state_t     state_nxt;
  logic [2:0] smp;
  logic [2:0] ipl_req;
  logic       level_stable;
  logic       nmi_edge;
  logic       nmi_set;
  logic       nmi_clr;
  logic       pending;

  assign ipl_req      = ~_ipl;
  assign level_stable = (ipl_req == smp);
  assign pending      = (ipl_level > ipl_mask) | nmi_edge;

  // A new level is only accepted when it is about to be committed and differs
  // from the current filtered level, so the edge is seen exactly once.
  assign nmi_set = level_stable && (smp == 3'd7) && (ipl_level != 3'd7);
  assign nmi_clr = (state == S_DONE) && (iack_level == 3'd7);

  // Two-sample glitch filter on the inverted IPL lines.
  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) begin
      smp       <= '0;
      ipl_level <= '0;
    end else if (clk7_en) begin
      smp <= ipl_req;
      if (level_stable) begin
        ipl_level <= smp;
      end
    end
  end

  // Level-7 edge latch; a fresh edge wins over a simultaneous clear.
  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) begin
      nmi_edge <= 1'b0;
    end else if (clk7_en) begin
      if (nmi_set) begin
        nmi_edge <= 1'b1;
      end else if (nmi_clr) begin
        nmi_edge <= 1'b0;
      end
    end
  end

  // Handshake state register.
  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) begin
      state <= S_IDLE;
    end else if (clk7_en) begin
      state <= state_nxt;
    end
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (pending) begin
          state_nxt = S_PEND;
        end
      end
      S_PEND: begin
        if (!pending) begin
          state_nxt = S_IDLE;
        end else if (cpu_ready) begin
          state_nxt = S_ACK;
        end
      end
      S_ACK: begin
        if (iack_berr || iack_ack) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Registered handshake outputs, updated from the state being left so that
  // iack_req falls on the same edge where int_taken rises.
  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) begin
      iack_req   <= 1'b0;
      iack_level <= '0;
      int_taken  <= 1'b0;
      vector     <= '0;
      new_mask   <= '0;
    end else if (clk7_en) begin
      int_taken <= 1'b0;
      case (state)
        S_PEND: begin
          if (pending && cpu_ready) begin
            iack_req   <= 1'b1;
            iack_level <= nmi_edge ? 3'd7 : ipl_level;
          end
        end
        S_ACK: begin
          if (iack_berr) begin
            vector <= VEC_BASE;
          end else if (iack_ack) begin
            vector <= VEC_BASE + {5'b00000, iack_level};
          end
        end
        S_DONE: begin
          iack_req  <= 1'b0;
          int_taken <= 1'b1;
          new_mask  <= iack_level;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_paula_ipl_responder.sv
// Scoreboard bench for paula_ipl_responder: stimulus pushes expected IACK
// requests and completions, a negedge monitor pops and compares them.
module tb_paula_ipl_responder;

  logic       clk;
  logic       _reset;
  logic       clk7_en;
  logic [2:0] _ipl;
  logic [2:0] ipl_mask;
  logic       cpu_ready;
  logic       iack_ack;
  logic       iack_berr;
  logic       iack_req;
  logic [2:0] iack_level;
  logic       int_taken;
  logic [7:0] vector;
  logic [2:0] new_mask;
  logic [2:0] ipl_level;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int         kind;   // 0 = iack request, 1 = int_taken completion
    logic [2:0] lvl;
    logic [7:0] vec;
    logic [2:0] msk;
  } exp_t;

  exp_t sb[$];

  paula_ipl_responder dut (
    .clk        (clk),
    ._reset     (_reset),
    .clk7_en    (clk7_en),
    ._ipl       (_ipl),
    .ipl_mask   (ipl_mask),
    .cpu_ready  (cpu_ready),
    .iack_ack   (iack_ack),
    .iack_berr  (iack_berr),
    .iack_req   (iack_req),
    .iack_level (iack_level),
    .int_taken  (int_taken),
    .vector     (vector),
    .new_mask   (new_mask),
    .ipl_level  (ipl_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic push_req(input logic [2:0] lvl);
    exp_t e;
    e.kind = 0; e.lvl = lvl; e.vec = 8'h00; e.msk = 3'd0;
    sb.push_back(e);
  endtask

  task automatic push_take(input logic [7:0] vec, input logic [2:0] msk);
    exp_t e;
    e.kind = 1; e.lvl = 3'd0; e.vec = vec; e.msk = msk;
    sb.push_back(e);
  endtask

  // Each call passes n enabled rising edges, each followed by a gated one.
  task automatic en(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      clk7_en = 1'b1;
      @(negedge clk);
      clk7_en = 1'b0;
    end
  endtask

  // Monitor: compares each request rise and completion pulse with the queue.
  logic req_q = 1'b0;
  logic tk_q  = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (_reset) begin
      if (iack_req && !req_q) begin
        if (sb.size() == 0 || sb[0].kind != 0) begin
          chk("unexpected_iack_req", 8'd1, 8'd0);
        end else begin
          e = sb.pop_front();
          chk("iack_level", {5'b0, iack_level}, {5'b0, e.lvl});
        end
      end
      if (int_taken && !tk_q) begin
        if (sb.size() == 0 || sb[0].kind != 1) begin
          chk("unexpected_int_taken", 8'd1, 8'd0);
        end else begin
          e = sb.pop_front();
          chk("vector", vector, e.vec);
          chk("new_mask", {5'b0, new_mask}, {5'b0, e.msk});
          chk("req_low_at_taken", {7'b0, iack_req}, 8'd0);
        end
      end
    end
    req_q = iack_req;
    tk_q  = int_taken;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    _reset    = 1'b0;
    clk7_en   = 1'b0;
    _ipl      = 3'b111;
    ipl_mask  = 3'd3;
    cpu_ready = 1'b1;
    iack_ack  = 1'b0;
    iack_berr = 1'b0;
    #1;
    chk("rst_iack_req", {7'b0, iack_req}, 8'd0);
    chk("rst_int_taken", {7'b0, int_taken}, 8'd0);
    chk("rst_vector", vector, 8'd0);
    chk("rst_ipl_level", {5'b0, ipl_level}, 8'd0);
    repeat (3) @(negedge clk);
    _reset = 1'b1;
    en(3);

    // Basic level 4 with latency and pulse-width checks.
    push_req(3'd4);
    push_take(8'h1C, 3'd4);
    _ipl = 3'b011;
    en(3);
    chk("lat_before_req", {7'b0, iack_req}, 8'd0);
    en(1);
    chk("lat_req", {7'b0, iack_req}, 8'd1);
    chk("lat_level", {5'b0, ipl_level}, 8'd4);
    iack_ack = 1'b1;
    _ipl     = 3'b111;
    en(1);
    iack_ack = 1'b0;
    chk("ack_edge_taken", {7'b0, int_taken}, 8'd0);
    chk("ack_edge_req", {7'b0, iack_req}, 8'd1);
    en(1);
    chk("taken_high", {7'b0, int_taken}, 8'd1);
    chk("taken_req_low", {7'b0, iack_req}, 8'd0);
    en(1);
    chk("taken_one_cycle", {7'b0, int_taken}, 8'd0);
    en(3);

    // Masked level and single-enable glitch.
    ipl_mask = 3'd2;
    _ipl     = 3'b101;
    en(20);
    chk("masked_no_req", {7'b0, iack_req}, 8'd0);
    chk("masked_level", {5'b0, ipl_level}, 8'd2);
    _ipl = 3'b000;
    en(1);
    _ipl = 3'b101;
    chk("glitch_level_a", {5'b0, ipl_level}, 8'd2);
    en(1);
    chk("glitch_level_b", {5'b0, ipl_level}, 8'd2);
    en(3);
    chk("glitch_level_c", {5'b0, ipl_level}, 8'd2);
    chk("glitch_no_req", {7'b0, iack_req}, 8'd0);
    _ipl = 3'b111;
    en(3);

    // NMI edge with mask 7, held level must not retrigger.
    ipl_mask = 3'd7;
    for (int k = 0; k < 2; k++) begin
      push_req(3'd7);
      push_take(8'h1F, 3'd7);
      _ipl = 3'b000;
      en(4);
      chk("nmi_req", {7'b0, iack_req}, 8'd1);
      iack_ack = 1'b1;
      en(1);
      iack_ack = 1'b0;
      en(2);
      en(20);
      chk("nmi_no_retrigger", {7'b0, iack_req}, 8'd0);
      _ipl = 3'b111;
      en(3);
    end

    // Withdrawn request while the CPU is busy.
    ipl_mask  = 3'd3;
    cpu_ready = 1'b0;
    _ipl      = 3'b010;
    en(3);
    _ipl = 3'b111;
    en(4);
    cpu_ready = 1'b1;
    en(4);
    chk("withdrawn_no_req", {7'b0, iack_req}, 8'd0);

    // Frozen level during ACK.
    push_req(3'd5);
    push_take(8'h1D, 3'd5);
    _ipl = 3'b010;
    en(4);
    chk("frozen_req", {7'b0, iack_req}, 8'd1);
    _ipl     = 3'b111;
    ipl_mask = 3'd7;
    en(5);
    chk("frozen_req_held", {7'b0, iack_req}, 8'd1);
    chk("frozen_level", {5'b0, iack_level}, 8'd5);
    iack_ack = 1'b1;
    en(1);
    iack_ack = 1'b0;
    en(3);
    ipl_mask = 3'd3;

    // Spurious: bus error beats a simultaneous ack.
    push_req(3'd4);
    push_take(8'h18, 3'd4);
    _ipl = 3'b011;
    en(4);
    _ipl      = 3'b111;
    iack_berr = 1'b1;
    iack_ack  = 1'b1;
    en(1);
    iack_berr = 1'b0;
    iack_ack  = 1'b0;
    en(3);
    chk("spurious_taken_done", {7'b0, int_taken}, 8'd0);

    // Asynchronous reset mid-ACK.
    push_req(3'd4);
    _ipl = 3'b011;
    en(4);
    chk("pre_reset_req", {7'b0, iack_req}, 8'd1);
    @(negedge clk);
    #2;
    _reset = 1'b0;
    #1;
    chk("async_rst_req", {7'b0, iack_req}, 8'd0);
    chk("async_rst_level", {5'b0, iack_level}, 8'd0);
    chk("async_rst_vector", vector, 8'd0);
    chk("async_rst_mask", {5'b0, new_mask}, 8'd0);
    chk("async_rst_ipl", {5'b0, ipl_level}, 8'd0);
    chk("async_rst_taken", {7'b0, int_taken}, 8'd0);
    _ipl = 3'b111;
    repeat (2) @(negedge clk);
    _reset = 1'b1;
    en(3);

    // Enable gating: no sampling while clk7_en is low.
    _ipl = 3'b011;
    repeat (10) @(negedge clk);
    chk("gated_level", {5'b0, ipl_level}, 8'd0);
    chk("gated_req", {7'b0, iack_req}, 8'd0);
    en(1);
    chk("gated_first_en_level", {5'b0, ipl_level}, 8'd0);
    _ipl = 3'b111;
    en(4);

    chk("scoreboard_empty", sb.size()[7:0], 8'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
